dot_product_sched: RTL and testbench

- Sequencer/arbiter that shares one bitwise dot-product (popcount of a&b) datapath between two requesters.
- Each requester streams a job of one or more 32-bit word pairs, with the last word flagged.
- The block grants one requester per whole job, accumulates per-word results, and returns one sum per job over a valid/ready result port.
- Sits between vector producers and result consumers in the compute cluster.

---
 rtl/dot_product_sched.sv | 166 ++++++++++++++++
 tb/tb_dot_product_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sched.sv
// rtl/dot_product_sched.sv - two-requester arbiter sharing one popcount(a&b) accumulate datapath
// Optional feature macro: DOTP_SCHED_JOBCNT_EN adds per-requester completed-job counters.
`timescale 1ns/1ps
module dot_product_sched #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [31:0]      s0_a,
    input  logic [31:0]      s0_b,
    input  logic             s0_last,
    input  logic             s1_valid,
    output logic             s1_ready,
    input  logic [31:0]      s1_a,
    input  logic [31:0]      s1_b,
    input  logic             s1_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_id,
    output logic             res_ovf,
    output logic             busy
`ifdef DOTP_SCHED_JOBCNT_EN
    ,
    output logic [15:0]      job_cnt0,
    output logic [15:0]      job_cnt1
`endif
);

    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic             beat;
    logic             word_last;
    logic [31:0]      word_and;
    logic [5:0]       pc;
    logic [SUM_W-1:0] sum;
    logic             handshake;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

    // The owner's lane is muxed onto the single datapath; the other lane is never looked at in BUSY.
    always_comb begin
        word_and  = owner_q ? (s1_a & s1_b) : (s0_a & s0_b);
        word_last = owner_q ? s1_last : s0_last;
        beat      = (state_q == BUSY) && (owner_q ? s1_valid : s0_valid);
        pc        = popcount32(word_and);
        sum       = SUM_W'(acc_q) + SUM_W'(pc);
        handshake = (state_q == DONE) && res_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s0_valid || s1_valid) state_d = BUSY;
            BUSY:    if (beat && word_last)    state_d = DONE;
            DONE:    if (res_ready)            state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Arbitration and accumulation; ovf stays set for the rest of the job once saturated.
    always_comb begin
        rr_d    = rr_q;
        owner_d = owner_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    owner_d = (s0_valid && s1_valid) ? rr_q : s1_valid;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            BUSY: begin
                if (beat) begin
                    if (sum[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                end
            end
            DONE: begin
                if (res_ready) rr_d = ~owner_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        s0_ready  = (state_q == BUSY) && !owner_q;
        s1_ready  = (state_q == BUSY) &&  owner_q;
        res_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    assign res_data = acc_q;
    assign res_id   = owner_q;
    assign res_ovf  = ovf_q;

`ifdef DOTP_SCHED_JOBCNT_EN
    logic [15:0] job_cnt0_q, job_cnt0_d;
    logic [15:0] job_cnt1_q, job_cnt1_d;

    always_comb begin
        job_cnt0_d = job_cnt0_q;
        job_cnt1_d = job_cnt1_q;
        if (handshake) begin
            if (owner_q) job_cnt1_d = job_cnt1_q + 16'd1;
            else         job_cnt0_d = job_cnt0_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            job_cnt0_q <= '0;
            job_cnt1_q <= '0;
        end else begin
            job_cnt0_q <= job_cnt0_d;
            job_cnt1_q <= job_cnt1_d;
        end
    end

    assign job_cnt0 = job_cnt0_q;
    assign job_cnt1 = job_cnt1_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_dot_product_sched.sv
// tb/tb_dot_product_sched.sv - directed scoreboard bench for dot_product_sched (ACC_W=16 and ACC_W=6 copies)
`timescale 1ns/1ps
module tb_dot_product_sched;

`define CHK(tag, obs, exp) \
    begin \
        total++; \
        assert ((obs) === (exp)) else begin \
            bad++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

    typedef struct {
        int d16;
        bit o16;
        int d6;
        bit o6;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid [2];
    logic [31:0] s_a [2];
    logic [31:0] s_b [2];
    logic        s_last [2];
    logic        res_ready;

    logic        s0_ready, s1_ready, res_valid, res_id, res_ovf, busy;
    logic [15:0] res_data;
    logic        s0_ready_6, s1_ready_6, res_valid_6, res_id_6, res_ovf_6, busy_6;
    logic [5:0]  res_data_6;
`ifdef DOTP_SCHED_JOBCNT_EN
    logic [15:0] job_cnt0, job_cnt1, job_cnt0_6, job_cnt1_6;
`endif

    int   total = 0;
    int   bad   = 0;
    int   cnt_m [2];
    exp_t sb0 [$];
    exp_t sb1 [$];

    always #5 clk = ~clk;

    dot_product_sched #(.ACC_W(16)) dut (
        .clk(clk), .reset(reset),
        .s0_valid(s_valid[0]), .s0_ready(s0_ready), .s0_a(s_a[0]), .s0_b(s_b[0]), .s0_last(s_last[0]),
        .s1_valid(s_valid[1]), .s1_ready(s1_ready), .s1_a(s_a[1]), .s1_b(s_b[1]), .s1_last(s_last[1]),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .res_ovf(res_ovf), .busy(busy)
`ifdef DOTP_SCHED_JOBCNT_EN
        , .job_cnt0(job_cnt0), .job_cnt1(job_cnt1)
`endif
    );

    dot_product_sched #(.ACC_W(6)) dut6 (
        .clk(clk), .reset(reset),
        .s0_valid(s_valid[0]), .s0_ready(s0_ready_6), .s0_a(s_a[0]), .s0_b(s_b[0]), .s0_last(s_last[0]),
        .s1_valid(s_valid[1]), .s1_ready(s1_ready_6), .s1_a(s_a[1]), .s1_b(s_b[1]), .s1_last(s_last[1]),
        .res_valid(res_valid_6), .res_ready(res_ready), .res_data(res_data_6),
        .res_id(res_id_6), .res_ovf(res_ovf_6), .busy(busy_6)
`ifdef DOTP_SCHED_JOBCNT_EN
        , .job_cnt0(job_cnt0_6), .job_cnt1(job_cnt1_6)
`endif
    );

    function automatic logic rdy(input int p);
        return (p == 0) ? s0_ready : s1_ready;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0; s_last[i] = 1'b0; s_a[i] = '0; s_b[i] = '0;
            cnt_m[i] = 0;
        end
        res_ready = 1'b0;
        sb0.delete();
        sb1.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Drives one job of n identical words; pushes the expected sums for both accumulator widths.
    task automatic run_job(input int p, input int n, input logic [31:0] a, input logic [31:0] b,
                           input int bub_after, input int bub_len);
        int   pc;
        int   r16;
        int   k;
        exp_t e;
        pc = $countones(a & b);
        e.d16 = 0; e.o16 = 0; e.d6 = 0; e.o6 = 0;
        for (int w = 0; w < n; w++) begin
            if (e.d16 + pc > 65535) begin e.d16 = 65535; e.o16 = 1; end else e.d16 += pc;
            if (e.d6 + pc > 63)     begin e.d6  = 63;    e.o6  = 1; end else e.d6  += pc;
        end
        if (p == 0) sb0.push_back(e); else sb1.push_back(e);
        r16 = 0;
        for (int w = 1; w <= n; w++) begin
            s_valid[p] = 1'b1; s_a[p] = a; s_b[p] = b; s_last[p] = (w == n);
            k = 0;
            while (rdy(p) !== 1'b1 && k < 300) begin @(negedge clk); k++; end
            `CHK("job_accept", rdy(p), 1'b1)
            @(negedge clk);
            r16 = (r16 + pc > 65535) ? 65535 : r16 + pc;
            if (w == bub_after) begin
                s_valid[p] = 1'b0;
                repeat (bub_len) begin
                    `CHK("bubble_acc_hold", res_data, r16[15:0])
                    `CHK("bubble_no_result", res_valid, 1'b0)
                    @(negedge clk);
                end
            end
        end
        s_valid[p] = 1'b0;
        s_last[p]  = 1'b0;
    endtask

    // Waits for a result, optionally stalls it, then pops and checks against the scoreboard.
    task automatic collect(input int exp_id, input int hold);
        int          k;
        exp_t        e;
        logic [15:0] d0;
        logic        i0;
        k = 0;
        while (res_valid !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        `CHK("res_valid_seen", res_valid, 1'b1)
        d0 = res_data;
        i0 = res_id;
        repeat (hold) begin
            @(negedge clk);
            `CHK("bp_valid_held", res_valid, 1'b1)
            `CHK("bp_data_stable", res_data, d0)
            `CHK("bp_id_stable", res_id, i0)
            `CHK("bp_s0_ready_low", s0_ready, 1'b0)
            `CHK("bp_s1_ready_low", s1_ready, 1'b0)
        end
        `CHK("res_id", res_id, exp_id[0])
        if ((exp_id == 0) ? (sb0.size() > 0) : (sb1.size() > 0)) begin
            e = (exp_id == 0) ? sb0.pop_front() : sb1.pop_front();
            `CHK("res_data", res_data, e.d16[15:0])
            `CHK("res_ovf", res_ovf, e.o16)
            `CHK("res_data_w6", res_data_6, e.d6[5:0])
            `CHK("res_ovf_w6", res_ovf_6, e.o6)
        end else begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty observed=result expected=none for id %0d", exp_id);
        end
        res_ready = 1'b1;
        cnt_m[exp_id]++;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic mon_s1_blocked();
        int k;
        k = 0;
        while (s0_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        `CHK("arb_s0_granted", s0_ready, 1'b1)
        while (res_valid !== 1'b1 && k < 60) begin
            `CHK("arb_s1_blocked", s1_ready, 1'b0)
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0; s_last[i] = 1'b0; s_a[i] = '0; s_b[i] = '0;
            cnt_m[i] = 0;
        end
        repeat (2) @(negedge clk);
        `CHK("rst_res_valid", res_valid, 1'b0)
        `CHK("rst_res_data", res_data, 16'h0)
        `CHK("rst_res_id", res_id, 1'b0)
        `CHK("rst_res_ovf", res_ovf, 1'b0)
        `CHK("rst_s0_ready", s0_ready, 1'b0)
        `CHK("rst_s1_ready", s1_ready, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_res_data_w6", res_data_6, 6'h0)
`ifdef DOTP_SCHED_JOBCNT_EN
        `CHK("rst_job_cnt0", job_cnt0, 16'h0)
        `CHK("rst_job_cnt1", job_cnt1, 16'h0)
`endif
        reset = 1'b1;

        // Single-word job: exact grant / accept / result cycle positions.
        @(negedge clk);
        sb0.push_back('{d16: 8, o16: 0, d6: 8, o6: 0});
        s_valid[0] = 1'b1; s_a[0] = 32'hFFFF_FFFF; s_b[0] = 32'h0000_00FF; s_last[0] = 1'b1;
        `CHK("lat_c0_s0_ready", s0_ready, 1'b0)
        @(negedge clk);
        `CHK("lat_c1_s0_ready", s0_ready, 1'b1)
        `CHK("lat_c1_s1_ready", s1_ready, 1'b0)
        `CHK("lat_c1_busy", busy, 1'b1)
        `CHK("lat_c1_res_valid", res_valid, 1'b0)
        @(negedge clk);
        s_valid[0] = 1'b0; s_last[0] = 1'b0;
        `CHK("lat_c2_s0_ready", s0_ready, 1'b0)
        `CHK("lat_c2_res_valid", res_valid, 1'b1)
        collect(0, 0);
        `CHK("post_hs_busy", busy, 1'b0)
        `CHK("post_hs_res_valid", res_valid, 1'b0)

        // Multi-word job from requester 1 with a two-cycle bubble before the last word.
        run_job(1, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 2);
        collect(1, 0);

        // Contention after reset: 0 first, then 1, then 0 again.
        do_reset();
        fork
            run_job(0, 2, 32'hF0F0_F0F0, 32'hFFFF_0000, 0, 0);
            run_job(1, 2, 32'hF0F0_F0F0, 32'hFFFF_0000, 0, 0);
            mon_s1_blocked();
            begin collect(0, 0); collect(1, 0); end
        join
        fork
            run_job(0, 1, 32'h0000_00FF, 32'h0000_0F0F, 0, 0);
            run_job(1, 1, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0);
            begin collect(0, 0); collect(1, 0); end
        join

        // Saturation on the narrow copy, then a fresh job must start with ovf clear.
        do_reset();
        run_job(0, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        collect(0, 0);
        run_job(0, 1, 32'h0000_0001, 32'h0000_0003, 0, 0);
        collect(0, 0);

        // Result backpressure for five cycles.
        run_job(0, 1, 32'h0000_000F, 32'h0000_00FF, 0, 0);
        collect(0, 5);
        `CHK("bp_idle_after_hs", busy, 1'b0)

        // Reset in the middle of a job; rr must come back as 0 (last grant before was requester 0).
        s_valid[0] = 1'b1; s_a[0] = 32'hFFFF_FFFF; s_b[0] = 32'hFFFF_FFFF; s_last[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        `CHK("mid_acc_partial", res_data, 16'd32)
        s_valid[0] = 1'b0;
        reset = 1'b0;
        #1;
        `CHK("mid_rst_res_data", res_data, 16'h0)
        `CHK("mid_rst_busy", busy, 1'b0)
        `CHK("mid_rst_s0_ready", s0_ready, 1'b0)
        `CHK("mid_rst_res_valid", res_valid, 1'b0)
`ifdef DOTP_SCHED_JOBCNT_EN
        `CHK("mid_rst_job_cnt0", job_cnt0, 16'h0)
`endif
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        @(negedge clk);
        reset = 1'b1;
        fork
            run_job(0, 1, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 0, 0);
            run_job(1, 1, 32'h5555_5555, 32'hFFFF_FFFF, 0, 0);
            begin collect(0, 0); collect(1, 0); end
        join
        run_job(0, 2, 32'h0000_FFFF, 32'h00FF_00FF, 0, 0);
        collect(0, 0);
        run_job(0, 1, 32'h8000_0001, 32'h8000_0001, 0, 0);
        collect(0, 0);
`ifdef DOTP_SCHED_JOBCNT_EN
        `CHK("job_cnt0", job_cnt0, cnt_m[0][15:0])
        `CHK("job_cnt1", job_cnt1, cnt_m[1][15:0])
        `CHK("job_cnt0_w6", job_cnt0_6, 16'd3)
        `CHK("job_cnt1_w6", job_cnt1_6, 16'd1)
`endif
        `CHK("sb0_drained", sb0.size(), 0)
        `CHK("sb1_drained", sb1.size(), 0)

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
